shift_add_mult: RTL and testbench

Sequential unsigned shift-and-add multiplier that sits directly upstream of, and drives, the team's full-adder datapath. It accepts two WIDTH-bit operands through a start/ready handshake and iterates one partial-product addition per clock through a WIDTH-bit ripple-carry adder built from `full_addr` cells. It returns a 2·WIDTH-bit product with a one-cycle `done` pulse. It trades the area of an array multiplier for WIDTH+1 cycles of latency.

---
 rtl/mult_pkg.sv | 22 ++
 rtl/full_addr.sv | 14 +
 rtl/ripple_addr.sv | 30 +++
 rtl/shift_add_mult.sv | 109 ++++++++++
 tb/tb_shift_add_mult.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM encoding,
// counter sizing helper and the default operand width.
package mult_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to count 0..n-1; never less than one bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/full_addr.sv
// One-bit full adder cell.
// Ports: a, b, cin -> s (sum), cout (carry out).
module full_addr (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/ripple_addr.sv
// WIDTH-bit ripple-carry adder built from a chain of full_addr cells,
// carry propagating from bit 0 upward.
// Ports: a, b (WIDTH), cin -> s (WIDTH), cout.
module ripple_addr #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  logic [WIDTH:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_addr u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (s[i]),
      .cout (c[i+1])
    );
  end

  assign cout = c[WIDTH];

endmodule

// File: rtl/shift_add_mult.sv
// Sequential unsigned shift-and-add multiplier. One partial-product
// addition per clock through a WIDTH-bit ripple adder; the 2*WIDTH-bit
// product is delivered with a one-cycle done pulse.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   start, a, b      request and operands, taken while ready=1
//   ready            high in IDLE
//   busy             high in CALC and DONE
//   done             one-cycle completion pulse
//   product          result register, held until next completion/reset
module shift_add_mult
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CW = clog2(WIDTH);
  localparam int unsigned SW = 2 * WIDTH + 1;

  state_t            state, state_d;
  logic              ready_d, busy_d, done_d;
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  mcand;
  logic [SW-1:0]     sreg;       // {carry, acc, low}

  logic [WIDTH-1:0]  acc;
  logic [WIDTH-1:0]  addend;
  logic [WIDTH-1:0]  sum;
  logic              cout;
  logic [SW-1:0]     shifted;
  logic              accept;
  logic              last;

  assign acc    = sreg[2*WIDTH-1:WIDTH];
  assign addend = sreg[0] ? mcand : '0;
  assign accept = (state == IDLE) && start;
  assign last   = (state == CALC) && (cnt == CW'(WIDTH - 1));

  // The carry bit is always 0 after a shift, so feeding it as cin keeps
  // the adder's carry-in at 0 while keeping the bit observable.
  ripple_addr #(.WIDTH(WIDTH)) u_add (
    .a    (acc),
    .b    (addend),
    .cin  (sreg[SW-1]),
    .s    (sum),
    .cout (cout)
  );

  // Adder carry-out lands in the acc MSB as everything shifts right by one.
  assign shifted = {1'b0, cout, sum, sreg[WIDTH-1:1]};

  // Next-state and next-output logic.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (last)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d == CALC) || (state_d == DONE);
    done_d  = (state_d == DONE);
  end

  // State and status output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      ready <= ready_d;
      busy  <= busy_d;
      done  <= done_d;
    end
  end

  // Operand capture, iteration datapath and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      mcand   <= '0;
      sreg    <= '0;
      product <= '0;
    end else if (accept) begin
      cnt   <= '0;
      mcand <= a;
      sreg  <= {1'b0, {WIDTH{1'b0}}, b};
    end else if (state == CALC) begin
      cnt  <= cnt + CW'(1);
      sreg <= shifted;
      if (last) product <= shifted[2*WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_shift_add_mult.sv
// Directed self-checking bench for shift_add_mult (WIDTH=8 and WIDTH=4).
module tb_shift_add_mult;

  logic        clk = 1'b0;
  logic        rst;
  logic        start8, start4;
  logic [7:0]  a8, b8;
  logic [3:0]  a4, b4;
  logic        ready8, busy8, done8;
  logic        ready4, busy4, done4;
  logic [15:0] prod8;
  logic [7:0]  prod4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  shift_add_mult #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .ready(ready8), .busy(busy8), .done(done8), .product(prod8)
  );

  shift_add_mult #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .ready(ready4), .busy(busy4), .done(done4), .product(prod4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done8(output int edges);
    edges = 0;
    while (!done8 && edges < 64) begin
      tick();
      edges++;
    end
    if (!done8) chk("done8_timeout", 32'(done8), 32'd1);
  endtask

  task automatic wait_done4(output int edges);
    edges = 0;
    while (!done4 && edges < 64) begin
      tick();
      edges++;
    end
    if (!done4) chk("done4_timeout", 32'(done4), 32'd1);
  endtask

  // Called in a ready cycle; leaves the bench in the ready cycle after done.
  task automatic mult8(input logic [7:0] x, input logic [7:0] y,
                       input logic [15:0] exp, input string tag);
    int e;
    a8 = x; b8 = y; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom);
    chk({tag, "_busy"}, 32'(busy8), 32'd1);
    wait_done8(e);
    chk({tag, "_latency"}, 32'(e), 32'd8);
    chk({tag, "_product"}, 32'(prod8), 32'(exp));
    tick();
    chk({tag, "_done_pulse"}, 32'(done8), 32'd0);
    chk({tag, "_ready_after"}, 32'(ready8), 32'd1);
  endtask

  initial begin
    int e;
    int pulses;
    rst = 1'b1; start8 = 1'b0; start4 = 1'b0;
    a8 = '0; b8 = '0; a4 = '0; b4 = '0;
    repeat (2) tick();
    chk("rst_ready", 32'(ready8), 32'd1);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_product", 32'(prod8), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_ready", 32'(ready8), 32'd1);

    mult8(8'hFF, 8'hFF, 16'hFE01, "ff_ff");
    mult8(8'h00, 8'hA5, 16'h0000, "zero_a");
    mult8(8'h5A, 8'h00, 16'h0000, "zero_b");

    // start held through CALC must not recapture; back-to-back after done
    a8 = 8'd3; b8 = 8'd5; start8 = 1'b1;
    tick();
    a8 = 8'd7; b8 = 8'd7;
    wait_done8(e);
    chk("held_latency", 32'(e), 32'd8);
    chk("held_product", 32'(prod8), 32'h000F);
    tick();
    chk("held_ready", 32'(ready8), 32'd1);
    chk("held_product_stable", 32'(prod8), 32'h000F);
    tick();
    start8 = 1'b0;
    chk("b2b_busy", 32'(busy8), 32'd1);
    wait_done8(e);
    chk("b2b_latency", 32'(e), 32'd8);
    chk("b2b_product", 32'(prod8), 32'h0031);
    tick();
    chk("b2b_ready", 32'(ready8), 32'd1);

    // reset during iteration 4 aborts
    a8 = 8'hFF; b8 = 8'h0F; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (4) tick();
    chk("abort_busy_before", 32'(busy8), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_ready", 32'(ready8), 32'd1);
    chk("abort_busy", 32'(busy8), 32'd0);
    chk("abort_product", 32'(prod8), 32'd0);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (done8) pulses++;
      tick();
    end
    chk("abort_no_done", 32'(pulses), 32'd0);
    mult8(8'h12, 8'h34, 16'h03A8, "after_abort");

    // reset wins over start in the same cycle
    a8 = 8'h11; b8 = 8'h11; rst = 1'b1; start8 = 1'b1;
    tick();
    rst = 1'b0; start8 = 1'b0;
    chk("rst_start_ready", 32'(ready8), 32'd1);
    chk("rst_start_busy", 32'(busy8), 32'd0);
    tick();
    chk("rst_start_idle", 32'(busy8), 32'd0);
    chk("rst_start_product", 32'(prod8), 32'd0);

    // WIDTH=4 exhaustive, back-to-back
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        a4 = 4'(x); b4 = 4'(y); start4 = 1'b1;
        tick();
        start4 = 1'b0;
        wait_done4(e);
        chk($sformatf("w4_latency_%0d_%0d", x, y), 32'(e), 32'd4);
        chk($sformatf("w4_product_%0d_%0d", x, y), 32'(prod4), 32'(x * y));
        tick();
        chk($sformatf("w4_done_pulse_%0d_%0d", x, y), 32'(done4), 32'd0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
